// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared op/state enums and HI/LO write request type for the mul/div unit
package mul_div_unit_pkg;

    localparam int HILO_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    typedef struct packed {
        logic                  valid;
        logic [HILO_WIDTH-1:0] data;
    } hilo_write_req;

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - execute-side request/stall and HI/LO write request bundle
interface mul_div_unit_if #(parameter int WIDTH = 32);
    import mul_div_unit_pkg::*;

    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             ready;
    logic             busy;
    hilo_write_req    hi_req;
    hilo_write_req    lo_req;

    modport master (
        output start, op, src_a, src_b, flush,
        input  ready, busy, hi_req, lo_req
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output ready, busy, hi_req, lo_req
    );

endinterface

// File: rtl/mul_div_unit_div_radix2.sv
// rtl/mul_div_unit_div_radix2.sv - radix-2 restoring divide core on unsigned magnitudes
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             run;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // quotient/remainder expose this cycle's step so the owner can capture on the final iteration
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        fits     = ~diff[WIDTH];
        rem_step = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], fits};
    end

    assign quotient  = quo_step;
    assign remainder = rem_step;
    assign done      = run && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run <= 1'b0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (kill) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (run) begin
            quo <= quo_step;
            rem <= rem_step;
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit feeding HI/LO write requests
// Optional: MULDIV_FAST_MULT_EN selects a single-cycle multiply in the MUL state.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave md
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldiv_state_t      state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   a_mag_r;
    logic [2*WIDTH-1:0] prod_r;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic               mul_last;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic               div_done;

    assign accept = (state == ST_IDLE) && md.start && !md.flush;

    always_comb begin
        a_neg = is_signed_op(md.op) && md.src_a[WIDTH-1];
        b_neg = is_signed_op(md.op) && md.src_b[WIDTH-1];
        a_mag = a_neg ? -md.src_a : md.src_a;
        b_mag = b_neg ? -md.src_b : md.src_b;
    end

`ifdef MULDIV_FAST_MULT_EN
    assign mul_step = {{WIDTH{1'b0}}, a_mag_r} * {{WIDTH{1'b0}}, prod_r[WIDTH-1:0]};
    assign mul_last = 1'b1;
`else
    // shift-add: low half holds the unconsumed multiplier bits, high half accumulates
    logic [WIDTH:0] mul_sum;
    assign mul_sum  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, a_mag_r} : '0);
    assign mul_step = {mul_sum, prod_r[WIDTH-1:1]};
    assign mul_last = (cnt == LAST);
`endif

    assign prod_fix = neg_q ? -mul_step : mul_step;

    div_radix2 #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && is_div_op(md.op)),
        .kill      (md.flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = is_div_op(md.op) ? ST_DIV : ST_MUL;
            ST_MUL:  if (md.flush) state_next = ST_IDLE;
                     else if (mul_last) state_next = ST_DONE;
            ST_DIV:  if (md.flush) state_next = ST_IDLE;
                     else if (cnt == LAST) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        md.ready  = (state == ST_IDLE);
        md.busy   = (state != ST_IDLE);
        md.hi_req = '0;
        md.lo_req = '0;
        if (state == ST_DONE && !md.flush) begin
            md.hi_req = '{valid: 1'b1, data: res_hi};
            md.lo_req = '{valid: 1'b1, data: res_lo};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            a_r      <= '0;
            a_mag_r  <= '0;
            prod_r   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            res_hi   <= '0;
            res_lo   <= '0;
        end else if (accept) begin
            cnt      <= '0;
            a_r      <= md.src_a;
            a_mag_r  <= a_mag;
            prod_r   <= {{WIDTH{1'b0}}, b_mag};
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (md.src_b == '0);
        end else if (md.flush) begin
            cnt <= '0;
        end else if (state == ST_MUL || state == ST_DIV) begin
            cnt <= cnt + 1'b1;
            if (state == ST_MUL) begin
                prod_r <= mul_step;
                if (mul_last) begin
                    res_hi <= prod_fix[2*WIDTH-1:WIDTH];
                    res_lo <= prod_fix[WIDTH-1:0];
                end
            end
            if (state == ST_DIV && div_done) begin
                res_hi <= div_zero ? a_r : (neg_r ? -div_rem : div_rem);
                res_lo <= div_zero ? '1 : (neg_q ? -div_quo : div_quo);
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed vector and corner-sequence bench for mul_div_unit
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) md();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input muldiv_op_t op);
`ifdef MULDIV_FAST_MULT_EN
        if (!is_div_op(op)) return 2;
`endif
        return 33;
    endfunction

    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int lat = -1;
        int pulses = 0;
        int stray = 0;
        int last_k;
        logic [31:0] gh = '0;
        logic [31:0] gl = '0;
        logic rdy_after = 1'b0;
        last_k = exp_lat(op) + 1;
        check({name, " ready_before"}, {31'b0, md.ready}, 32'd1);
        md.op = op; md.src_a = a; md.src_b = b; md.start = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            if (k > 1) @(negedge clk);
            if (md.hi_req.valid && md.lo_req.valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; gh = md.hi_req.data; gl = md.lo_req.data;
                end
            end else if (md.hi_req.valid || md.lo_req.valid ||
                         md.hi_req.data != 0 || md.lo_req.data != 0) begin
                stray++;
            end
            if (k == last_k) rdy_after = md.ready;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat(op)));
        check({name, " pulses"}, 32'(pulses), 32'd1);
        check({name, " stray_out"}, 32'(stray), 32'd0);
        check({name, " hi"}, gh, eh);
        check({name, " lo"}, gl, el);
        check({name, " ready_after"}, {31'b0, rdy_after}, 32'd1);
    endtask

    task automatic watch_quiet(input int cycles, input string name);
        int pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (md.hi_req.valid || md.lo_req.valid) pulses++;
        end
        check({name, " no_valid"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [31:0] gh, gl;

        vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{MD_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{MD_DIVU,  32'd9,         32'd4,         32'd1,         32'd2};
        vecs[6]  = '{MD_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[7]  = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[8]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{MD_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[10] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[11] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{MD_MULTU, 32'd0,         32'd5,         32'd0,         32'd0};
        vecs[13] = '{MD_DIVU,  32'h8000_0000, 32'd3,         32'd2,         32'h2AAA_AAAA};

        md.start = 1'b0; md.op = MD_MULT; md.src_a = '0; md.src_b = '0; md.flush = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ready", {31'b0, md.ready}, 32'd1);
        check("reset busy", {31'b0, md.busy}, 32'd0);
        check("reset hi_req", {31'b0, md.hi_req.valid} | md.hi_req.data, 32'd0);
        check("reset lo_req", {31'b0, md.lo_req.valid} | md.lo_req.data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

        // flush during iteration 10 of a divide
        md.op = MD_DIVU; md.src_a = 32'd1000; md.src_b = 32'd7; md.start = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            if (md.hi_req.valid || md.lo_req.valid) pulses++;
            if (k == 10) begin
                check("flush_iter busy", {31'b0, md.busy}, 32'd1);
                md.flush = 1'b1;
                #1;
                if (md.hi_req.valid || md.lo_req.valid) pulses++;
            end
            if (k == 11) begin
                check("flush_iter ready", {31'b0, md.ready}, 32'd1);
                md.flush = 1'b0;
            end
        end
        check("flush_iter pulses", 32'(pulses), 32'd0);
        watch_quiet(40, "flush_iter tail");

        // flush during DONE
        md.op = MD_DIVU; md.src_a = 32'd50; md.src_b = 32'd5; md.start = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 34; k++) begin
            if (k > 1) @(negedge clk);
            if (k < 33 && (md.hi_req.valid || md.lo_req.valid)) pulses++;
            if (k == 33) begin
                check("flush_done busy", {31'b0, md.busy}, 32'd1);
                md.flush = 1'b1;
                #1;
                if (md.hi_req.valid || md.lo_req.valid) pulses++;
                check("flush_done hi_data", md.hi_req.data, 32'd0);
            end
            if (k == 34) begin
                check("flush_done ready", {31'b0, md.ready}, 32'd1);
                md.flush = 1'b0;
            end
        end
        check("flush_done pulses", 32'(pulses), 32'd0);
        run_op(MD_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, "after_flush");

        // asynchronous reset mid-divide
        md.op = MD_DIV; md.src_a = 32'hFFFF_FF9C; md.src_b = 32'd3; md.start = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        repeat (14) @(negedge clk);
        check("async_rst busy_before", {31'b0, md.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst ready", {31'b0, md.ready}, 32'd1);
        check("async_rst busy", {31'b0, md.busy}, 32'd0);
        check("async_rst outs", {30'b0, md.hi_req.valid, md.lo_req.valid} | md.hi_req.data | md.lo_req.data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        watch_quiet(40, "async_rst tail");

        // start held through busy: operands changed mid-op must not be taken until ready
        md.op = MD_DIVU; md.src_a = 32'd9; md.src_b = 32'd4; md.start = 1'b1;
        @(negedge clk);
        md.src_a = 32'd100; md.src_b = 32'd7;
        pulses = 0; gh = '0; gl = '0;
        for (int k = 1; k <= 67; k++) begin
            if (k > 1) @(negedge clk);
            if (md.hi_req.valid) begin
                pulses++;
                if (k == 33) begin gh = md.hi_req.data; gl = md.lo_req.data; end
                if (k == 67) begin
                    check("held_start second hi", md.hi_req.data, 32'd2);
                    check("held_start second lo", md.lo_req.data, 32'd14);
                end
            end
            if (k == 33) check("held_start first_valid", {31'b0, md.hi_req.valid}, 32'd1);
            if (k == 34) begin
                check("held_start ready", {31'b0, md.ready}, 32'd1);
            end
            if (k == 35) begin
                check("held_start reaccepted", {31'b0, md.busy}, 32'd1);
                md.start = 1'b0;
            end
        end
        md.start = 1'b0;
        check("held_start first hi", gh, 32'd1);
        check("held_start first lo", gl, 32'd2);
        check("held_start pulses", 32'(pulses), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
